// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit FND display path.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_DEC    = 10;

    // One BCD digit slot.
    typedef logic [3:0] digit_t;

    // Active-low segment codes (g..a) for 0..F, identical to the driver's table.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All segments dark.
    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Four BCD digits to binary; 9999 fits in 14 bits.
    function automatic logic [13:0] bcd_to_bin(input digit_t d3, input digit_t d2,
                                               input digit_t d1, input digit_t d0);
        return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational segment-to-BCD decoder; only 0..9 and blank are legal.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic       is_digit,
    output logic       is_blank,
    output digit_t     bcd
);

    // Search the decimal part of the shared code table for a match.
    always_comb begin
        // NOTE: outputs get defaults before any conditional write, so no latch is inferred.
        is_digit = 1'b0;
        bcd      = '0;
        for (int i = 0; i < NUM_DEC; i++) begin
            if (seg == SEG_CODE[i]) begin
                is_digit = 1'b1;
                bcd      = digit_t'(i);
            end
        end
    end

    assign is_blank = (seg == BLANK_SEG);

endmodule

// File: rtl/fnd_scan_capture.sv
// Snoops multiplexed FND common/segment lines, decodes each settled digit
// and reassembles complete 4-digit frames into a binary value.
module fnd_scan_capture
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fndCom,
    input  logic [7:0]  fndfont,
    output logic [13:0] fndValue,
    output logic [3:0]  dp_on,
    output logic        valid,
    output logic        err_com,
    output logic        err_code,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;

    logic [3:0]    com_q, com_d, com_prev_q, com_prev_d;
    logic [7:0]    font_q, font_d, font_prev_q, font_prev_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          strobe_q, strobe_d;
    logic          pair_changed;

    logic [3:0]    mask_q, mask_d;
    digit_t        slot_q [NUM_DIGITS];
    digit_t        slot_d [NUM_DIGITS];
    logic [3:0]    dp_q, dp_d;
    logic [13:0]   value_q, value_d;
    logic          valid_q, valid_d;
    logic          err_com_q, err_com_d;
    logic          err_code_q, err_code_d;
    logic          stale_q, stale_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [0:0]    state_q, state_d;

    logic [3:0]    cap_com;
    logic [7:0]    cap_font;
    logic [2:0]    n_low;
    logic [1:0]    pos;
    logic [3:0]    mask_set;
    logic          dec_is_digit, dec_is_blank;
    digit_t        dec_bcd;

    // The pair seen on the strobe cycle is the one that settled.
    assign cap_com  = com_prev_q;
    assign cap_font = font_prev_q;

    fnd_seg_decode u_seg_decode (
        .seg      (cap_font[6:0]),
        .is_digit (dec_is_digit),
        .is_blank (dec_is_blank),
        .bcd      (dec_bcd)
    );

    // Input register, settle counter and the one-shot capture strobe.
    always_comb begin
        com_d        = fndCom;
        font_d       = fndfont;
        com_prev_d   = com_q;
        font_prev_d  = font_q;
        pair_changed = ({com_q, font_q} != {com_prev_q, font_prev_q});
        if (pair_changed)
            settle_d = SW'(1);
        else if (settle_q == SETTLE_MAX)
            settle_d = settle_q;
        else
            settle_d = settle_q + 1'b1;
        // Fires on the transition into the saturated count, never while parked there.
        strobe_d = (settle_d == SETTLE_MAX) && (pair_changed || settle_q != SETTLE_MAX);
    end

    // Capture decision, frame assembly, emit and timeout tracking.
    always_comb begin
        mask_d     = mask_q;
        slot_d     = slot_q;
        dp_d       = dp_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        err_com_d  = 1'b0;
        err_code_d = 1'b0;
        state_d    = ST_COLLECT;

        n_low = '0;
        pos   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!cap_com[i]) begin
                n_low = n_low + 1'b1;
                pos   = 2'(i);
            end
        end
        mask_set = mask_q | (4'b0001 << pos);

        if (strobe_q && n_low != 3'd0) begin
            if (n_low > 3'd1) begin
                err_com_d = 1'b1;
                mask_d    = '0;
            end else if (dec_is_digit) begin
                slot_d[pos] = dec_bcd;
                dp_d[pos]   = ~cap_font[7];
                if (mask_set == 4'b1111) begin
                    mask_d  = '0;
                    state_d = ST_EMIT;
                end else begin
                    mask_d = mask_set;
                end
            end else if (dec_is_blank) begin
                dp_d[pos] = ~cap_font[7];
            end else begin
                err_code_d = 1'b1;
                mask_d     = '0;
            end
        end

        if (state_q == ST_EMIT) begin
            value_d = bcd_to_bin(slot_q[3], slot_q[2], slot_q[1], slot_q[0]);
            valid_d = 1'b1;
            stale_d = 1'b0;
            tcnt_d  = '0;
        end else begin
            tcnt_d  = (tcnt_q == TIMEOUT_MAX) ? tcnt_q : tcnt_q + 1'b1;
            stale_d = stale_q | (tcnt_d == TIMEOUT_MAX);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            com_q       <= '1;
            font_q      <= '1;
            com_prev_q  <= '1;
            font_prev_q <= '1;
            settle_q    <= '0;
            strobe_q    <= 1'b0;
            mask_q      <= '0;
            // NOTE: the digit slots are only four small registers, so they are reset along
            // with everything else; a frame can never complete from pre-reset contents.
            slot_q      <= '{default: '0};
            dp_q        <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            err_com_q   <= 1'b0;
            err_code_q  <= 1'b0;
            stale_q     <= 1'b1;
            tcnt_q      <= '0;
            state_q     <= ST_COLLECT;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            com_q       <= com_d;
            font_q      <= font_d;
            com_prev_q  <= com_prev_d;
            font_prev_q <= font_prev_d;
            settle_q    <= settle_d;
            strobe_q    <= strobe_d;
            mask_q      <= mask_d;
            slot_q      <= slot_d;
            dp_q        <= dp_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_com_q   <= err_com_d;
            err_code_q  <= err_code_d;
            stale_q     <= stale_d;
            tcnt_q      <= tcnt_d;
            state_q     <= state_d;
        end
    end

    assign fndValue = value_q;
    assign dp_on    = dp_q;
    assign valid    = valid_q;
    assign err_com  = err_com_q;
    assign err_code = err_code_q;
    assign stale    = stale_q;

endmodule

// File: doc/fnd_scan_capture.md
Name: fnd_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit FND driver.
- Snoops the time-multiplexed common and segment lines (fndCom, fndfont) and decodes each active digit's segment pattern back to BCD.
- Reassembles the four digits into the 14-bit value being displayed and raises a valid pulse once per complete frame.
- Used as a loopback checker and in-system monitor beside the display controller.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles a com/font pair must hold unchanged before it is captured (min 1).
- TIMEOUT_CYCLES, 1_000_000: cycles without a completed frame before stale asserts (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- fndCom  in  4  digit commons, active-low; bit0 = ones digit … bit3 = thousands digit.
- fndfont  in  8  segments, active-low; bit7 = dp, bits[6:0] = g..a.
- fndValue  out  14  last complete decoded value, 0..9999.
- dp_on  out  4  latest dp state per position, 1 = lit.
- valid  out  1  one-cycle pulse when fndValue updates.
- err_com  out  1  one-cycle pulse: more than one fndCom bit low in a captured pair.
- err_code  out  1  one-cycle pulse: segment pattern is neither a digit 0–9 nor blank.
- stale  out  1  level: no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset (synchronous, active-high) clears all state: fndValue=0, dp_on=0, valid=0, err_com=0, err_code=0, stale=1, capture mask=0, counters=0. Reset asserted mid-frame discards the partial frame.
- Input stage: fndCom/fndfont are registered once.
- Settle counter: reloads to 1 whenever the registered pair differs from the previous cycle's pair; otherwise increments and saturates at SETTLE_CYCLES.
- Capture strobe: fires exactly once per hold, on the cycle the counter reaches SETTLE_CYCLES. A pair applied at edge k strobes at edge k+1+SETTLE_CYCLES.
- On strobe:
  - fndCom = 4'b1111: nothing is updated.
  - More than one fndCom bit low: err_com pulses, mask clears.
  - Otherwise the one low bit selects position p; lower-7 decode applies:
    - Digits, lower-7 → value: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9. Store the digit in slot p and set mask[p]. A repeat capture of p before the frame completes overwrites the slot (latest wins).
    - Blank (lower-7 = 0x7F): slot and mask are unchanged.
    - Any other pattern: err_code pulses, mask clears.
  - dp_on[p] <= ~fndfont[7] for every captured single-low pair, blank or digit.
- Frame complete:
  - On the strobe cycle that makes mask = 4'b1111, mask clears.
  - The next cycle registers fndValue = d3*1000 + d2*100 + d1*10 + d0, pulses valid, clears stale, and reloads the timeout counter.
  - Arithmetic uses 14-bit unsigned values; the maximum of 9999 cannot overflow.
- Timeout: counter increments every cycle and saturates. Reaching TIMEOUT_CYCLES sets stale, which holds until the next valid. fndValue keeps its last value.
- Error vs. frame completion on the same strobe is impossible; each strobe has exactly one outcome.
- Pulse outputs are never high for more than one consecutive cycle per event.
- States:
  - COLLECT (mask ≠ 1111)
  - EMIT (one cycle, value/valid registered)
  - back to COLLECT.

Decomposition:
- Package fnd_pkg holds:
  - the 16-entry segment code constants shared with the driver's BCD-to-segment table;
  - the BLANK_SEG (0x7F lower-7) constant;
  - NUM_DIGITS = 4;
  - a digit-slot typedef (logic [3:0]).
- Sub-module fnd_seg_decode: combinational, lower-7 segments in, {is_digit, is_blank, bcd[3:0]} out. Instantiated once in the top.

Test Plan:
- Full frame: present (1110,C0)(1101,F9)(1011,A4)(0111,B0), each held 8 cycles, SETTLE_CYCLES=4 → one valid pulse, fndValue=3210, stale=0.
- Glitch rejection: hold (1110,92) for 3 cycles then (1110,80) for 8 cycles, then complete the remaining digits with 0 → fndValue ends in digit 8, not 5; no extra valid.
- Blank/dp interleave: digits 1,2,3,4 interleaved with (1101,7F) and (1101,FF) → fndValue=4321, dp_on[1] toggles 1 then 0, no err_code.
- Bad inputs: capture (1100,C0) → err_com pulse, mask cleared; capture (1110,0xAA) → err_code pulse; a following clean frame still yields a correct valid.
- Timeout: TIMEOUT_CYCLES=50, no frames → stale=1 from cycle 50, fndValue retains its last value; the next frame clears stale with valid.
- Reset mid-frame: capture 3 digits, assert rst for 1 cycle, then send only the 4th digit → no valid; all outputs read their reset values.
